// File: rtl/dbg_loader.sv
// Debug host-link controller: decodes a UART byte stream into CPU hold/release
// and word read/write accesses on the debug memory port, and returns replies.
module dbg_loader #(
   parameter bit          BOOT_HOLD = 1'b0,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        cpu_n_reset,
   output logic        dbg_mem_op,
   output logic [31:0] dbg_adr,
   output logic [31:0] dbg_do,
   output logic [3:0]  dbg_wren,
   input  logic [31:0] dbg_di,
   input  logic        dbg_ready
);

   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [7:0] OP_H    = 8'h48;
   localparam logic [7:0] OP_G    = 8'h47;
   localparam logic [7:0] OP_W    = 8'h57;
   localparam logic [7:0] OP_R    = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_BAD = 8'h3F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_MEM,
      S_RESP
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    last_q, last_d;
   logic          wr_q, wr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   do_q, do_d;
   logic [31:0]   rdat_q, rdat_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_valid_q, tx_valid_d;
   logic          cpu_n_reset_q, cpu_n_reset_d;
   logic          mem_op_q, mem_op_d;
   logic [3:0]    wren_q, wren_d;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      last_d        = last_q;
      wr_d          = wr_q;
      tmo_d         = tmo_q;
      adr_d         = adr_q;
      do_d          = do_q;
      rdat_d        = rdat_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      cpu_n_reset_d = cpu_n_reset_q;
      mem_op_d      = mem_op_q;
      wren_d        = wren_q;

      unique case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            idx_d = '0;
            if (rx_valid) begin
               last_d = '0;
               unique case (rx_data)
                  OP_H: begin
                     cpu_n_reset_d = 1'b0;
                     tx_data_d     = RSP_OK;
                     tx_valid_d    = 1'b1;
                     state_d       = S_RESP;
                  end
                  OP_G: begin
                     cpu_n_reset_d = 1'b1;
                     tx_data_d     = RSP_OK;
                     tx_valid_d    = 1'b1;
                     state_d       = S_RESP;
                  end
                  OP_W: begin
                     wr_d    = 1'b1;
                     state_d = S_ADDR;
                  end
                  OP_R: begin
                     wr_d    = 1'b0;
                     state_d = S_ADDR;
                  end
                  default: begin
                     tx_data_d  = RSP_BAD;
                     tx_valid_d = 1'b1;
                     state_d    = S_RESP;
                  end
               endcase
            end
         end

         // Fields arrive LSB first, so each byte shifts in from the top.
         S_ADDR: begin
            if (rx_valid) begin
               tmo_d = '0;
               adr_d = {rx_data, adr_q[31:8]};
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (wr_q) begin
                     state_d = S_DATA;
                  end else begin
                     state_d  = S_MEM;
                     mem_op_d = 1'b1;
                     wren_d   = 4'h0;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_DATA: begin
            if (rx_valid) begin
               tmo_d = '0;
               do_d  = {rx_data, do_q[31:8]};
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d  = S_MEM;
                  mem_op_d = 1'b1;
                  wren_d   = 4'hF;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         // The first reply byte is loaded directly from dbg_di so it can go out
         // the cycle after dbg_ready; the rest come from the latched word.
         S_MEM: begin
            if (dbg_ready) begin
               mem_op_d   = 1'b0;
               wren_d     = 4'h0;
               rdat_d     = dbg_di;
               tx_data_d  = wr_q ? RSP_OK : dbg_di[7:0];
               tx_valid_d = 1'b1;
               idx_d      = '0;
               last_d     = wr_q ? 2'd0 : 2'd3;
               state_d    = S_RESP;
            end
         end

         S_RESP: begin
            if (tx_valid_q && tx_ready) begin
               if (idx_q == last_q) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  idx_d     = idx_q + 2'd1;
                  tx_data_d = rdat_q[15:8];
                  rdat_d    = {8'h00, rdat_q[31:8]};
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         last_q        <= '0;
         wr_q          <= 1'b0;
         tmo_q         <= '0;
         adr_q         <= '0;
         do_q          <= '0;
         rdat_q        <= '0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         cpu_n_reset_q <= ~BOOT_HOLD;
         mem_op_q      <= 1'b0;
         wren_q        <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         wr_q          <= wr_d;
         tmo_q         <= tmo_d;
         adr_q         <= adr_d;
         do_q          <= do_d;
         rdat_q        <= rdat_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         cpu_n_reset_q <= cpu_n_reset_d;
         mem_op_q      <= mem_op_d;
         wren_q        <= wren_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign cpu_n_reset = cpu_n_reset_q;
   assign dbg_mem_op  = mem_op_q;
   assign dbg_adr     = adr_q & 32'hFFFF_FFFC;
   assign dbg_do      = do_q;
   assign dbg_wren    = wren_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Scoreboard bench for dbg_loader: expected reply bytes and memory requests are
// queued by the stimulus process and checked by independent monitors.
module tb_dbg_loader;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cpu_n_reset;
   logic        dbg_mem_op;
   logic [31:0] dbg_adr;
   logic [31:0] dbg_do;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_di;
   logic        dbg_ready;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  wren;
   } mreq_t;

   logic [7:0] exp_tx[$];
   mreq_t      exp_mem[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned rdy_mode = 1;
   int unsigned mem_delay = 0;
   logic [31:0] mem_rdata = '0;

   dbg_loader #(
      .BOOT_HOLD(1'b1),
      .TIMEOUT  (50)
   ) dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .cpu_n_reset(cpu_n_reset),
      .dbg_mem_op (dbg_mem_op),
      .dbg_adr    (dbg_adr),
      .dbg_do     (dbg_do),
      .dbg_wren   (dbg_wren),
      .dbg_di     (dbg_di),
      .dbg_ready  (dbg_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // tx_ready driver: 0 hold low, 1 hold high, 2 toggle every cycle
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ~tx_ready;
         endcase
      end
   end

   // memory responder: raises dbg_ready mem_delay cycles into a request
   initial begin
      int unsigned cnt = 0;
      dbg_ready = 1'b0;
      dbg_di    = '0;
      forever begin
         @(posedge clk);
         #1;
         dbg_di = mem_rdata;
         if (dbg_mem_op && !dbg_ready) begin
            if (cnt == mem_delay) dbg_ready = 1'b1;
            else cnt++;
         end else begin
            dbg_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // reply monitor
   initial begin
      forever begin
         @(negedge clk);
         if (n_reset && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL tx_unexpected: got %h required no byte", tx_data);
            end else begin
               chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
         end
      end
   end

   // memory request monitor
   initial begin
      logic  prev_op  = 1'b0;
      logic  prev_rdy = 1'b0;
      mreq_t cur      = '0;
      mreq_t e;
      forever begin
         @(negedge clk);
         if (!n_reset) begin
            prev_op  = 1'b0;
            prev_rdy = 1'b0;
         end else begin
            if (prev_rdy) begin
               chk("op_drop_after_ready", {31'h0, dbg_mem_op}, 32'h0);
               chk("wren_drop_after_ready", {28'h0, dbg_wren}, 32'h0);
               chk("tx_valid_after_ready", {31'h0, tx_valid}, 32'h1);
            end
            if (dbg_mem_op && !prev_op) begin
               cur = '{adr: dbg_adr, dat: dbg_do, wren: dbg_wren};
               if (exp_mem.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL mem_unexpected: got adr %h wren %h required no request",
                           dbg_adr, dbg_wren);
               end else begin
                  e = exp_mem.pop_front();
                  chk("req_adr", dbg_adr, e.adr);
                  chk("req_wren", {28'h0, dbg_wren}, {28'h0, e.wren});
                  if (e.wren == 4'hF) chk("req_do", dbg_do, e.dat);
               end
            end else if (dbg_mem_op) begin
               chk("req_adr_stable", dbg_adr, cur.adr);
               chk("req_do_stable", dbg_do, cur.dat);
               chk("req_wren_stable", {28'h0, dbg_wren}, {28'h0, cur.wren});
            end
            if (dbg_mem_op) chk("no_reply_during_req", {31'h0, tx_valid}, 32'h0);
            prev_op  = dbg_mem_op;
            prev_rdy = dbg_mem_op && dbg_ready;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int unsigned budget);
      int unsigned i = 0;
      while ((exp_tx.size() != 0 || exp_mem.size() != 0 || tx_valid || dbg_mem_op)
             && i < budget) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("done_within_bound", {31'h0, i < budget}, 32'h1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
      chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      chk({tag, "_mem_op"}, {31'h0, dbg_mem_op}, 32'h0);
      chk({tag, "_adr"}, dbg_adr, 32'h0);
      chk({tag, "_do"}, dbg_do, 32'h0);
      chk({tag, "_wren"}, {28'h0, dbg_wren}, 32'h0);
      chk({tag, "_cpu_n_reset"}, {31'h0, cpu_n_reset}, 32'h0);
   endtask

   initial begin
      n_reset  = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      n_reset = 1'b1;
      repeat (2) @(posedge clk);

      // G releases the held CPU
      exp_tx.push_back(8'h4B);
      send(8'h47);
      chk("g_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h1);
      chk("g_tx_valid", {31'h0, tx_valid}, 32'h1);
      wait_done(20);

      // H holds it again
      exp_tx.push_back(8'h4B);
      send(8'h48);
      chk("h_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h0);
      wait_done(20);

      // word write, slow memory, 40-cycle gap inside the address field
      mem_delay = 3;
      exp_mem.push_back('{adr: 32'h0002_0000, dat: 32'h0001_07B7, wren: 4'hF});
      exp_tx.push_back(8'h4B);
      send(8'h57);
      send(8'h00);
      send(8'h00);
      repeat (40) @(posedge clk);
      send(8'h02);
      send(8'h00);
      send(8'hB7);
      send(8'h07);
      send(8'h01);
      send(8'h00);
      chk("w_mem_op_rise", {31'h0, dbg_mem_op}, 32'h1);
      wait_done(40);

      // word read, same-cycle ready, tx_ready toggling
      mem_delay = 0;
      mem_rdata = 32'h0007_A023;
      exp_mem.push_back('{adr: 32'h0002_0004, dat: 32'h0, wren: 4'h0});
      exp_tx.push_back(8'h23);
      exp_tx.push_back(8'hA0);
      exp_tx.push_back(8'h07);
      exp_tx.push_back(8'h00);
      rdy_mode = 2;
      send(8'h52);
      send(8'h06);
      send(8'h00);
      send(8'h02);
      send(8'h00);
      chk("r_mem_op_rise", {31'h0, dbg_mem_op}, 32'h1);
      wait_done(40);
      rdy_mode = 1;

      // truncated write aborted by the gap timeout, then G works
      send(8'h57);
      send(8'h00);
      send(8'h00);
      send(8'h02);
      repeat (60) @(posedge clk);
      exp_tx.push_back(8'h4B);
      send(8'h47);
      chk("tmo_g_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h1);
      wait_done(20);

      // unknown opcode; strobes during a held reply are dropped
      rdy_mode = 0;
      exp_tx.push_back(8'h3F);
      send(8'h00);
      send(8'h48);
      send(8'h48);
      send(8'h52);
      chk("held_tx_valid", {31'h0, tx_valid}, 32'h1);
      chk("held_tx_data", {24'h0, tx_data}, 32'h3F);
      chk("held_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h1);
      rdy_mode = 1;
      wait_done(20);
      repeat (3) @(posedge clk);
      #1;
      chk("after_held_cpu_n_reset", {31'h0, cpu_n_reset}, 32'h1);

      // reset in the data phase of a write
      mem_rdata = 32'h1234_5678;
      send(8'h57);
      send(8'h08);
      send(8'h00);
      send(8'h03);
      send(8'h00);
      send(8'hAA);
      send(8'hBB);
      #3;
      n_reset = 1'b0;
      #1;
      chk_reset_outputs("abort");
      repeat (2) @(posedge clk);
      #2;
      n_reset = 1'b1;
      repeat (2) @(posedge clk);
      exp_mem.push_back('{adr: 32'h0003_0008, dat: 32'h0, wren: 4'h0});
      exp_tx.push_back(8'h78);
      exp_tx.push_back(8'h56);
      exp_tx.push_back(8'h34);
      exp_tx.push_back(8'h12);
      send(8'h52);
      send(8'h08);
      send(8'h00);
      send(8'h03);
      send(8'h00);
      wait_done(40);
      chk("tail_tx_queue_empty", exp_tx.size(), 32'h0);
      chk("tail_mem_queue_empty", exp_mem.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
